// File: rtl/clk_switch_pkg.sv
// Shared types for the clock-switch sequencer: FSM state encoding and the response record.
// Used by the controller, its interface, the SW-register wrapper and the bench.
package clk_switch_pkg;
  typedef enum logic [1:0] {IDLE, SWITCH, SETTLE, RESP} state_e;

  localparam int unsigned RSP_IDX_MAX_W = 8;

  typedef struct packed {
    logic [RSP_IDX_MAX_W-1:0] idx;
    logic                     err;
  } rsp_t;

  function automatic int unsigned width_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/clk_switch_ctrl_if.sv
// Request/response bundle between clock-source requesters and the switch controller.
// Handshake: a request transfers in the cycle where req_valid[k] & req_ready[k]; once raised, req_valid[k]
// and req_sel[k] hold until that cycle. rsp_valid is a one-cycle pulse carrying rsp_idx/rsp_err.
interface clk_switch_ctrl_if
  import clk_switch_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned NUM_INPUTS = 2
) ();
  localparam int unsigned SEL_W = width_min1(NUM_INPUTS);
  localparam int unsigned IDX_W = width_min1(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0][SEL_W-1:0] req_sel;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          rsp_valid;
  logic [IDX_W-1:0]              rsp_idx;
  logic                          rsp_err;
  rsp_t                          rsp;
  logic [SEL_W-1:0]              sel;
  logic                          busy;
  state_e                        state;

  modport master (
    output req_valid, req_sel,
    input  req_ready, rsp_valid, rsp_idx, rsp_err, rsp, sel, busy, state
  );

  modport slave (
    input  req_valid, req_sel,
    output req_ready, rsp_valid, rsp_idx, rsp_err, rsp, sel, busy, state
  );
endinterface

// File: rtl/clk_switch_ctrl_arb.sv
// Round-robin arbiter: the first valid requester at or after the pointer wins; the pointer moves to winner+1.
// An offered grant that is not taken is locked so the winner cannot change underneath a pending handshake.
module rr_arb_tree #(
  parameter int unsigned NumIn    = 2,
  parameter int unsigned IdxWidth = 1,
  parameter bit          LockIn   = 1'b1,
  parameter bit          ExtPrio  = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                take,
  input  logic [NumIn-1:0]    req,
  output logic [NumIn-1:0]    gnt,
  output logic [IdxWidth-1:0] idx
);
  if (ExtPrio) begin : g_bad_prio
    $error("rr_arb_tree: external priority is not supported");
  end

  logic [IdxWidth-1:0] ptr_q;
  logic [IdxWidth-1:0] lock_idx_q;
  logic                lock_q;
  logic [IdxWidth-1:0] rr_idx;
  logic                any;

  always_comb begin
    any    = 1'b0;
    rr_idx = '0;
    for (int off = 0; off < int'(NumIn); off++) begin
      if (!any && req[(int'(ptr_q) + off) % int'(NumIn)]) begin
        any    = 1'b1;
        rr_idx = IdxWidth'((int'(ptr_q) + off) % int'(NumIn));
      end
    end
  end

  assign idx = lock_q ? lock_idx_q : rr_idx;
  assign gnt = (en && any) ? (NumIn'(1) << idx) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else if (en && any) begin
      if (take) begin
        ptr_q  <= (32'(idx) == NumIn - 1) ? '0 : idx + 1'b1;
        lock_q <= 1'b0;
      end else if (LockIn) begin
        lock_q     <= 1'b1;
        lock_idx_q <= idx;
      end
    end
  end
endmodule

// File: rtl/clk_switch_ctrl.sv
// Sequencer/arbiter for a glitch-free clock mux: grants one switch request at a time, drives the mux
// select, holds it for SETTLE_CYCLES, then pulses a response to the granted requester.
module clk_switch_ctrl
  import clk_switch_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 2,
  parameter int unsigned NUM_INPUTS    = 2,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned RESET_SEL     = 0
) (
  input  logic             clk,
  input  logic             rst,
  clk_switch_ctrl_if.slave bus
);
  localparam int unsigned SelWidth   = width_min1(NUM_INPUTS);
  localparam int unsigned IdxWidth   = width_min1(NUM_REQ);
  localparam int unsigned CntWidth   = $clog2(SETTLE_CYCLES + 1);
  // SWITCH is the first hold cycle, so SETTLE only has to cover the remaining SETTLE_CYCLES-1.
  localparam int unsigned SettleLoad = (SETTLE_CYCLES > 1) ? SETTLE_CYCLES - 2 : 0;

  if (SETTLE_CYCLES == 0) begin : g_bad_settle
    $error("clk_switch_ctrl: SETTLE_CYCLES must be >= 1");
  end
  if (NUM_INPUTS < 2) begin : g_bad_inputs
    $error("clk_switch_ctrl: NUM_INPUTS must be >= 2");
  end
  if (RESET_SEL >= NUM_INPUTS) begin : g_bad_reset_sel
    $error("clk_switch_ctrl: RESET_SEL must be < NUM_INPUTS");
  end
  if (NUM_REQ == 0 || IdxWidth > RSP_IDX_MAX_W) begin : g_bad_req
    $error("clk_switch_ctrl: NUM_REQ out of range");
  end

  state_e              state_q, state_d;
  logic [SelWidth-1:0] sel_q, sel_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  rsp_t                rsp_q, rsp_d;

  logic [NUM_REQ-1:0]  gnt;
  logic [IdxWidth-1:0] gnt_idx;
  logic [SelWidth-1:0] gnt_sel;
  logic                arb_en;
  logic                grant;

  assign arb_en  = (state_q == IDLE) && !rst;
  assign grant   = |gnt;
  assign gnt_sel = bus.req_sel[gnt_idx];

  rr_arb_tree #(
    .NumIn    (NUM_REQ),
    .IdxWidth (IdxWidth),
    .LockIn   (1'b1),
    .ExtPrio  (1'b0)
  ) u_arb (
    .clk  (clk),
    .rst  (rst),
    .en   (arb_en),
    .take (arb_en),
    .req  (bus.req_valid),
    .gnt  (gnt),
    .idx  (gnt_idx)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    rsp_d   = rsp_q;
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          rsp_d.idx = RSP_IDX_MAX_W'(gnt_idx);
          rsp_d.err = 1'b0;
          if (32'(gnt_sel) >= NUM_INPUTS) begin
            rsp_d.err = 1'b1;
            state_d   = RESP;
          end else if (gnt_sel == sel_q) begin
            state_d = RESP;
          end else begin
            sel_d   = gnt_sel;
            state_d = SWITCH;
          end
        end
      end
      SWITCH: begin
        if (SETTLE_CYCLES == 1) begin
          state_d = RESP;
        end else begin
          cnt_d   = CntWidth'(SettleLoad);
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= SelWidth'(RESET_SEL);
      cnt_q   <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      rsp_q   <= rsp_d;
    end
  end

  assign bus.req_ready = gnt;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp       = rsp_q;
  assign bus.rsp_idx   = rsp_q.idx[IdxWidth-1:0];
  assign bus.rsp_err   = rsp_q.err;
  assign bus.sel       = sel_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.state     = state_q;

  a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(bus.req_ready));
  a_sel_stable:   assert property (@(posedge clk) disable iff (rst)
                    !(state_q == IDLE && state_d == SWITCH) |=> $stable(sel_q));
  a_sel_range:    assert property (@(posedge clk) disable iff (rst) 32'(sel_q) < NUM_INPUTS);
  a_rsp_pulse:    assert property (@(posedge clk) disable iff (rst) bus.rsp_valid |=> !bus.rsp_valid);

  for (genvar k = 0; k < int'(NUM_REQ); k++) begin : g_req_sva
    a_req_hold: assert property (@(posedge clk) disable iff (rst)
                  bus.req_valid[k] && !bus.req_ready[k] |=> bus.req_valid[k] && $stable(bus.req_sel[k]));
  end
endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Bench for clk_switch_ctrl: directed scenarios then random requests, checked every cycle against a
// timeline model (who wins, when sel moves, when each response is due).
module tb_clk_switch_ctrl;
  import clk_switch_pkg::*;

  localparam int NR = 2;
  localparam int NI = 3;
  localparam int SC = 16;
  localparam int RS = 0;
  localparam int SW = 2;
  localparam int IW = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  clk_switch_ctrl_if #(.NUM_REQ(NR), .NUM_INPUTS(NI)) bus ();

  clk_switch_ctrl #(
    .NUM_REQ       (NR),
    .NUM_INPUTS    (NI),
    .SETTLE_CYCLES (SC),
    .RESET_SEL     (RS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic          drv_valid [NR];
  logic [SW-1:0] drv_sel   [NR];

  // Reference timeline: cycle numbers at which the controller is free again and each response is due.
  int cyc       = 0;
  int free_at   = 0;
  int busy_from = 0;
  int ptr       = 0;
  int m_sel     = RS;
  logic [IW:0] exp_q[$];
  int          exp_t_q[$];
  int n_accepted = 0;
  int n_answered = 0;
  int n_aborted  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Valid requester closest to the pointer going upward, wrapping.
  function automatic int rr_pick();
    int best = -1;
    int bd   = NR;
    for (int k = 0; k < NR; k++) begin
      if (drv_valid[k]) begin
        int d;
        d = (k - ptr + NR) % NR;
        if (d < bd) begin
          bd   = d;
          best = k;
        end
      end
    end
    return best;
  endfunction

  task automatic cycle_body();
    logic [NR-1:0] exp_ready;
    logic [IW:0]   e;
    int            w;
    cyc++;
    for (int k = 0; k < NR; k++) begin
      bus.req_valid[k] = drv_valid[k];
      bus.req_sel[k]   = drv_sel[k];
    end
    #1;
    exp_ready = '0;
    w = (cyc >= free_at) ? rr_pick() : -1;
    if (w >= 0) exp_ready[w] = 1'b1;
    check("ready", 32'(bus.req_ready), 32'(exp_ready));
    check("busy", 32'(bus.busy), 32'(cyc >= busy_from && cyc < free_at));
    check("sel", 32'(bus.sel), 32'(m_sel));
    if (exp_t_q.size() > 0 && exp_t_q[0] == cyc) begin
      void'(exp_t_q.pop_front());
      e = exp_q.pop_front();
      check("rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("rsp_idx", 32'(bus.rsp_idx), 32'(e[IW:1]));
      check("rsp_err", 32'(bus.rsp_err), 32'(e[0]));
      n_answered++;
    end else begin
      check("rsp_idle", 32'(bus.rsp_valid), 32'd0);
    end
    if (w >= 0) begin
      n_accepted++;
      ptr       = (w + 1) % NR;
      busy_from = cyc + 1;
      if (int'(drv_sel[w]) >= NI) begin
        exp_q.push_back({IW'(w), 1'b1});
        exp_t_q.push_back(cyc + 1);
        free_at = cyc + 2;
      end else if (int'(drv_sel[w]) == m_sel) begin
        exp_q.push_back({IW'(w), 1'b0});
        exp_t_q.push_back(cyc + 1);
        free_at = cyc + 2;
      end else begin
        m_sel = int'(drv_sel[w]);
        exp_q.push_back({IW'(w), 1'b0});
        exp_t_q.push_back(cyc + SC + 1);
        free_at = cyc + SC + 2;
      end
      drv_valid[w] = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cycle_body();
  endtask

  task automatic do_reset(input bit clear);
    rst = 1'b1;
    #1;
    check("rst_sel", 32'(bus.sel), 32'(RS));
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    check("rst_rsp_idx", 32'(bus.rsp_idx), 32'd0);
    check("rst_state", 32'(bus.state), 32'(IDLE));
    n_aborted += exp_q.size();
    exp_q.delete();
    exp_t_q.delete();
    free_at   = 0;
    busy_from = 0;
    ptr       = 0;
    m_sel     = RS;
    if (clear) begin
      for (int k = 0; k < NR; k++) drv_valid[k] = 1'b0;
    end
    for (int k = 0; k < NR; k++) begin
      bus.req_valid[k] = drv_valid[k];
      bus.req_sel[k]   = drv_sel[k];
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cycle_body();
  endtask

  task automatic wait_idle(input int budget);
    int  n = 0;
    bool_loop: while (n < budget) begin
      logic pending = 1'b0;
      for (int k = 0; k < NR; k++) pending |= drv_valid[k];
      if (!pending && cyc >= free_at && exp_t_q.size() == 0) break;
      step();
      n++;
    end
    check("wait_idle", 32'(n < budget), 32'd1);
  endtask

  task automatic request(input int k, input int s);
    drv_sel[k]   = SW'(s);
    drv_valid[k] = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < NR; k++) begin
      drv_valid[k] = 1'b0;
      drv_sel[k]   = '0;
    end
    bus.req_valid = '0;
    bus.req_sel   = '0;
    #1;
    do_reset(1'b1);

    // Single switch to input 1: sel at T+1, response at T+17, idle at T+18.
    request(0, 1);
    wait_idle(40);

    // Reset while settling toward input 2: select snaps back, no response.
    request(0, 2);
    repeat (6) step();
    do_reset(1'b1);
    repeat (20) step();

    // Contention present at reset release, then a second simultaneous pair.
    request(0, 1);
    request(1, 0);
    do_reset(1'b0);
    wait_idle(80);
    request(0, 2);
    request(1, 1);
    wait_idle(80);

    // No-op: ask for the input already selected.
    request(0, 1);
    wait_idle(40);
    request(1, 1);
    wait_idle(10);

    // Out-of-range select is rejected.
    request(0, 3);
    wait_idle(10);

    // Back-pressure: req0 arrives while req1 is settling.
    request(1, 2);
    repeat (3) step();
    request(0, 0);
    wait_idle(80);

    // Random traffic with occasional resets.
    for (int i = 0; i < 40000 && n_accepted < 3000; i++) begin
      for (int k = 0; k < NR; k++) begin
        if (!drv_valid[k] && $urandom_range(0, 2) == 0) request(k, int'($urandom_range(0, 3)));
      end
      if ($urandom_range(0, 1999) == 0) do_reset(1'b1);
      else step();
    end
    wait_idle(100);

    check("answered_once", 32'(n_answered + n_aborted), 32'(n_accepted));
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
